// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_input_sequencer
//  Brief    : Debounced two-button front end that steps switch values into
//             operand A, operand B and opcode registers for a downstream ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] op,
    output logic [1:0] state,
    output logic       valid,
    output logic       op_err
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] c_OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        RUN     = 2'b11
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_enter};

    // Per button: synchronizer, debounce counter, one-cycle press detector.
    // A button held across reset release stays disarmed until it is seen low.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_d;
        logic               r_armed;
        logic [1:0]         r_fill;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_armed <= 1'b0;
                r_fill  <= 2'b00;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                r_fill  <= {r_fill[0], 1'b1};
                if (r_fill[1] && !r_sync2 && !r_deb) begin
                    r_armed <= 1'b1;
                end
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_deb & ~r_deb_d & r_armed;
    end

    logic       w_enter_p;
    logic       w_clear_p;
    state_t     r_state;
    state_t     w_nxt_state;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_op;
    logic       r_op_err;
    logic [3:0] w_nxt_a;
    logic [3:0] w_nxt_b;
    logic [3:0] w_nxt_op;
    logic       w_nxt_op_err;

    assign w_enter_p = w_press[0];
    assign w_clear_p = w_press[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LOAD_A;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_op     <= 4'd0;
            r_op_err <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_a      <= w_nxt_a;
            r_b      <= w_nxt_b;
            r_op     <= w_nxt_op;
            r_op_err <= w_nxt_op_err;
        end
    end

    // Clear has priority; a coincident enter is dropped.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_a      = r_a;
        w_nxt_b      = r_b;
        w_nxt_op     = r_op;
        w_nxt_op_err = r_op_err;
        if (w_clear_p) begin
            w_nxt_state  = LOAD_A;
            w_nxt_a      = 4'd0;
            w_nxt_b      = 4'd0;
            w_nxt_op     = 4'd0;
            w_nxt_op_err = 1'b0;
        end else if (w_enter_p) begin
            case (r_state)
                LOAD_A: begin
                    w_nxt_a     = sw;
                    w_nxt_state = LOAD_B;
                end
                LOAD_B: begin
                    w_nxt_b     = sw;
                    w_nxt_state = LOAD_OP;
                end
                LOAD_OP: begin
                    if (sw <= c_OP_MAX) begin
                        w_nxt_op     = sw;
                        w_nxt_op_err = 1'b0;
                        w_nxt_state  = RUN;
                    end else begin
                        w_nxt_op_err = 1'b1;
                    end
                end
                RUN: begin
                    w_nxt_state = LOAD_A;
                end
                default: begin
                    w_nxt_state = LOAD_A;
                end
            endcase
        end
    end

    assign A      = r_a;
    assign B      = r_b;
    assign op     = r_op;
    assign state  = r_state;
    assign valid  = (r_state == RUN);
    assign op_err = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_input_sequencer
//  Brief    : Directed self-checking bench for alu_input_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int c_HOLD = DEBOUNCE_CYCLES + 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] op;
    logic [1:0] state;
    logic       valid;
    logic       op_err;

    int n_vec = 0;
    int n_err = 0;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .A         (A),
        .B         (B),
        .op        (op),
        .state     (state),
        .valid     (valid),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] s, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] o, input logic v,
                             input logic e);
        check({tag, ".state"}, {6'd0, state}, {6'd0, s});
        check({tag, ".A"}, {4'd0, A}, {4'd0, a});
        check({tag, ".B"}, {4'd0, B}, {4'd0, b});
        check({tag, ".op"}, {4'd0, op}, {4'd0, o});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        check({tag, ".op_err"}, {7'd0, op_err}, {7'd0, e});
    endtask

    // Hold the chosen buttons long enough to be accepted, then release and
    // let the release settle.
    task automatic press(input logic e, input logic c, input logic [3:0] v);
        sw        = v;
        btn_enter = e;
        btn_clear = c;
        step(c_HOLD);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        step(c_HOLD);
    endtask

    // Enter press whose capture must land exactly on edge DEBOUNCE_CYCLES+3.
    task automatic press_timed(input string tag, input logic [3:0] v,
                               input logic [1:0] s_before, input logic [1:0] s_after);
        sw        = v;
        btn_enter = 1'b1;
        step(DEBOUNCE_CYCLES + 2);
        check({tag, ".early"}, {6'd0, state}, {6'd0, s_before});
        step(1);
        check({tag, ".ontime"}, {6'd0, state}, {6'd0, s_after});
        step(c_HOLD);
        btn_enter = 1'b0;
        step(c_HOLD);
    endtask

    initial begin
        rst_n     = 1'b0;
        sw        = 4'd0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        #3;
        check_all("reset", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(6);
        check_all("idle", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Three clean entries with exact press latency.
        press_timed("capA", 4'd3, 2'b00, 2'b01);
        check("capA.A", {4'd0, A}, 8'd3);
        press_timed("capB", 4'd5, 2'b01, 2'b10);
        check("capB.B", {4'd0, B}, 8'd5);
        press_timed("capOP", 4'd0, 2'b10, 2'b11);
        check_all("run", 2'b11, 4'd3, 4'd5, 4'd0, 1'b1, 1'b0);

        // Switch changes outside a capture edge are ignored.
        sw = 4'd14;
        step(8);
        check_all("sw_idle", 2'b11, 4'd3, 4'd5, 4'd0, 1'b1, 1'b0);

        // Long hold in RUN gives a single transition back to LOAD_A.
        sw        = 4'd15;
        btn_enter = 1'b1;
        step(100);
        check_all("hold_run", 2'b00, 4'd3, 4'd5, 4'd0, 1'b0, 1'b0);
        btn_enter = 1'b0;
        step(c_HOLD);
        check("hold_run.rel", {6'd0, state}, 8'd0);

        // Three one-cycle glitches, then a stable press.
        sw = 4'd6;
        for (int i = 0; i < 3; i++) begin
            btn_enter = 1'b1;
            step(1);
            btn_enter = 1'b0;
            step(2);
        end
        step(4);
        check("glitch.ignored", {6'd0, state}, 8'd0);
        btn_enter = 1'b1;
        step(20);
        check_all("glitch", 2'b01, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0);
        btn_enter = 1'b0;
        step(c_HOLD);

        // Clear alone from LOAD_B.
        press(1'b0, 1'b1, 4'd11);
        check_all("clear", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Clear and enter together in LOAD_B with A=9: clear wins.
        press(1'b1, 1'b0, 4'd9);
        check("setA9", {4'd0, A}, 8'd9);
        press(1'b1, 1'b1, 4'd4);
        check_all("clr_ent", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Illegal opcode rejected, then a legal one accepted.
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b0, 4'd12);
        check_all("op_bad", 2'b10, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 4'd7);
        check_all("op_ok", 2'b11, 4'd1, 4'd2, 4'd7, 1'b1, 1'b0);

        // Asynchronous reset between edges while in LOAD_OP.
        press(1'b1, 1'b0, 4'd10);
        press(1'b1, 1'b0, 4'd8);
        press(1'b1, 1'b0, 4'd2);
        check("pre_rst.state", {6'd0, state}, 8'd2);
        #2;
        rst_n     = 1'b0;
        btn_enter = 1'b1;
        #2;
        check_all("async_rst", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Button held through reset release must not produce a press.
        step(2);
        rst_n = 1'b1;
        sw    = 4'd8;
        step(30);
        check_all("held_rst", 2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        btn_enter = 1'b0;
        step(c_HOLD);
        press(1'b1, 1'b0, 4'd8);
        check_all("after_held", 2'b01, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
